// File: rtl/mem_phase_arbiter.sv
// Sequences NUM_CH processing phases over a single registered RAM port, with a
// one-cycle write guard between phases and an optional per-phase watchdog.
module mem_phase_arbiter #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 0,
   parameter int unsigned PH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_CH-1:0]          ch_wren,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH-1:0]          ch_done,
   output logic [NUM_CH-1:0]          ch_start,
   output logic [NUM_CH-1:0]          ch_grant,
   output logic [DATA_W-1:0]          mem_data,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_wren,
   output logic [PH_W-1:0]            phase,
   output logic                       busy,
   output logic                       all_done,
   output logic                       timeout_err
);

   typedef enum logic [1:0] {StIdle, StRun, StHandoff, StDone} state_e;

   state_e              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [NUM_CH-1:0]   ch_start_q, ch_start_d;
   logic [NUM_CH-1:0]   ch_grant_q, ch_grant_d;
   logic [DATA_W-1:0]   mem_data_q, mem_data_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_wren_q, mem_wren_d;
   logic                all_done_q, all_done_d;
   logic                timeout_err_q, timeout_err_d;
   logic [31:0]         cnt_q, cnt_d;

   logic [DATA_W-1:0]   sel_data;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_wren;
   logic                sel_done;
   logic                last_phase;
   logic                wd_fire;

   function automatic logic [NUM_CH-1:0] onehot(input logic [PH_W-1:0] p);
      logic [NUM_CH-1:0] oh;
      for (int k = 0; k < NUM_CH; k++) oh[k] = (p == PH_W'(k));
      return oh;
   endfunction

   // Only the active phase's channel is ever visible to the RAM port.
   always_comb begin
      sel_data = '0;
      sel_addr = '0;
      sel_wren = 1'b0;
      sel_done = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (phase_q == PH_W'(k)) begin
            sel_data = ch_data[k*DATA_W +: DATA_W];
            sel_addr = ch_addr[k*ADDR_W +: ADDR_W];
            sel_wren = ch_wren[k];
            sel_done = ch_done[k];
         end
      end
   end

   assign last_phase = (phase_q == PH_W'(NUM_CH - 1));
   assign wd_fire    = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         phase_q       <= '0;
         ch_start_q    <= '0;
         ch_grant_q    <= '0;
         mem_data_q    <= '0;
         mem_addr_q    <= '0;
         mem_wren_q    <= 1'b0;
         all_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         ch_start_q    <= ch_start_d;
         ch_grant_q    <= ch_grant_d;
         mem_data_q    <= mem_data_d;
         mem_addr_q    <= mem_addr_d;
         mem_wren_q    <= mem_wren_d;
         all_done_q    <= all_done_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StRun;
         StRun: begin
            // A done arriving on the watchdog edge takes priority.
            if (sel_done)     state_d = StHandoff;
            else if (wd_fire) state_d = StDone;
         end
         StHandoff: state_d = last_phase ? StDone : StRun;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      phase_d       = phase_q;
      ch_start_d    = ch_start_q;
      ch_grant_d    = ch_grant_q;
      mem_data_d    = mem_data_q;
      mem_addr_d    = mem_addr_q;
      mem_wren_d    = mem_wren_q;
      all_done_d    = all_done_q;
      timeout_err_d = timeout_err_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle, StDone: begin
            mem_wren_d = 1'b0;
            if (start) begin
               phase_d       = '0;
               ch_start_d    = onehot('0);
               ch_grant_d    = onehot('0);
               all_done_d    = 1'b0;
               timeout_err_d = 1'b0;
               cnt_d         = '0;
            end
         end
         StRun: begin
            mem_data_d = sel_data;
            mem_addr_d = sel_addr;
            mem_wren_d = sel_wren;
            ch_start_d = '0;
            cnt_d      = cnt_q + 32'd1;
            if (sel_done) begin
               ch_grant_d = '0;
            end else if (wd_fire) begin
               timeout_err_d = 1'b1;
               mem_wren_d    = 1'b0;
               ch_grant_d    = '0;
               all_done_d    = 1'b1;
            end
         end
         StHandoff: begin
            mem_wren_d = 1'b0;
            if (last_phase) begin
               all_done_d = 1'b1;
            end else begin
               phase_d    = phase_q + PH_W'(1);
               ch_start_d = onehot(phase_q + PH_W'(1));
               ch_grant_d = onehot(phase_q + PH_W'(1));
               cnt_d      = '0;
            end
         end
         default: ;
      endcase
   end

   assign busy        = (state_q == StRun) || (state_q == StHandoff);
   assign phase       = phase_q;
   assign ch_start    = ch_start_q;
   assign ch_grant    = ch_grant_q;
   assign mem_data    = mem_data_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wren    = mem_wren_q;
   assign all_done    = all_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_phase_arbiter.sv
// Bench for mem_phase_arbiter: three configurations run side by side, each with
// random channel traffic checked every cycle against a phase-level model.
module tb_mem_phase_arbiter;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic clk     = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input int cfg, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got 'h%0h, expected 'h%0h", cfg, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int unsigned NC   = (g == 2) ? 4 : 3;
      localparam int unsigned DW   = (g == 2) ? 16 : 8;
      localparam int unsigned AW   = (g == 2) ? 10 : 8;
      localparam int unsigned TO   = (g == 1) ? 16 : 0;
      localparam int unsigned PW   = $clog2(NC);
      localparam int unsigned MAXL = (g == 1) ? 20 : 12;
      localparam logic [AW-1:0] AA = AW'(8'hAA);

      logic             rst_n, start;
      logic [NC-1:0]    ch_wren, ch_done, ch_start, ch_grant;
      logic [NC*DW-1:0] ch_data;
      logic [NC*AW-1:0] ch_addr;
      logic [DW-1:0]    mem_data;
      logic [AW-1:0]    mem_addr;
      logic             mem_wren, busy, all_done, timeout_err;
      logic [PW-1:0]    phase;

      mem_phase_arbiter #(
         .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO), .PH_W(PW)
      ) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .ch_wren(ch_wren), .ch_data(ch_data),
         .ch_addr(ch_addr), .ch_done(ch_done), .ch_start(ch_start), .ch_grant(ch_grant),
         .mem_data(mem_data), .mem_addr(mem_addr), .mem_wren(mem_wren), .phase(phase),
         .busy(busy), .all_done(all_done), .timeout_err(timeout_err)
      );

      // Model: which phase owns the port, whether we sit in the guard gap, how long
      // the current phase has held the port, and the expected registered outputs.
      int            m_ph = 0, m_held = 0;
      bit            m_run = 0, m_gap = 0, chk_on = 0;
      logic [NC-1:0] e_start = '0, e_grant = '0;
      logic [DW-1:0] e_data = '0;
      logic [AW-1:0] e_addr = '0;
      logic          e_wren = 0, e_all = 0, e_err = 0;

      always @(posedge clk) begin
         if (!rst_n) begin
            m_ph = 0; m_run = 0; m_gap = 0; m_held = 0;
            e_start = '0; e_grant = '0; e_data = '0; e_addr = '0;
            e_wren = 0; e_all = 0; e_err = 0; chk_on = 1;
         end else if (m_run) begin
            e_data  = ch_data[m_ph*DW +: DW];
            e_addr  = ch_addr[m_ph*AW +: AW];
            e_wren  = ch_wren[m_ph];
            e_start = '0;
            m_held++;
            if (ch_done[m_ph]) begin
               e_grant = '0; m_run = 0; m_gap = 1;
            end else if (TO > 0 && m_held == TO) begin
               e_wren = 0; e_grant = '0; e_err = 1; e_all = 1; m_run = 0;
            end
         end else if (m_gap) begin
            m_gap  = 0;
            e_wren = 0;
            if (m_ph == NC - 1) e_all = 1;
            else begin
               m_ph++;
               e_start = NC'(1) << m_ph;
               e_grant = e_start;
               m_run   = 1;
               m_held  = 0;
            end
         end else if (start) begin
            m_ph = 0; e_start = NC'(1); e_grant = NC'(1);
            e_all = 0; e_err = 0; m_run = 1; m_held = 0;
         end
      end

      always @(negedge clk) begin
         if (chk_on) begin
            chk(g, "ch_start", ch_start, e_start);
            chk(g, "ch_grant", ch_grant, e_grant);
            chk(g, "mem_data", mem_data, e_data);
            chk(g, "mem_addr", mem_addr, e_addr);
            chk(g, "mem_wren", mem_wren, e_wren);
            chk(g, "phase", phase, m_ph);
            chk(g, "busy", busy, m_run || m_gap);
            chk(g, "all_done", all_done, e_all);
            chk(g, "timeout_err", timeout_err, e_err);
         end
      end

      // Channel drivers: the granted channel runs len[k] cycles then raises done;
      // everyone else hammers address AA with writes and random done pulses.
      int idx [NC];
      int len [NC];
      bit lin_mode = 0;
      bit fin = 0;

      always @(negedge clk) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         logic          w, dn;
         for (int k = 0; k < NC; k++) begin
            if (ch_grant[k]) begin
               if (lin_mode && k == 0) begin
                  a = AW'(idx[k]); d = DW'(idx[k]); w = 1'b1;
               end else begin
                  a = AW'($urandom);
                  if (a == AA) a = a ^ AW'(1);
                  d = DW'($urandom); w = 1'($urandom);
               end
               dn = (idx[k] == len[k] - 1);
               idx[k]++;
            end else begin
               idx[k] = 0;
               a = AA; d = DW'($urandom); w = 1'b1; dn = ($urandom_range(2) == 0);
            end
            ch_addr[k*AW +: AW] = a;
            ch_data[k*DW +: DW] = d;
            ch_wren[k] = w;
            ch_done[k] = dn;
         end
      end

      task automatic pulse_start();
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      endtask

      task automatic wait_end(input int limit);
         bit seen = 0;
         for (int i = 0; i < limit; i++) begin
            if (all_done && !busy) begin
               seen = 1;
               break;
            end
            @(negedge clk);
         end
         chk(g, "sequence completes", seen, 1);
      endtask

      task automatic random_run(input int r);
         int rst_at;
         bit seen = 0;
         for (int k = 0; k < NC; k++) len[k] = 1 + int'($urandom_range(MAXL - 1));
         rst_at = (r % 5 == 3) ? int'($urandom_range(30)) : -1;
         pulse_start();
         for (int i = 0; i < 500; i++) begin
            if (all_done && !busy) begin
               seen = 1;
               break;
            end
            if (i == rst_at) begin
               rst_n = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               seen  = 1;
               break;
            end
            start = busy && ($urandom_range(9) == 0);
            @(negedge clk);
         end
         start = 1'b0;
         chk(g, "run completes", seen, 1);
         repeat ($urandom_range(3)) @(negedge clk);
      endtask

      initial begin
         int wr, gcnt;
         bit hit;
         logic [AW-1:0] last_a;
         logic [NC-1:0] seq [$];
         rst_n = 1'b0;
         start = 1'b0;
         for (int k = 0; k < NC; k++) len[k] = 4;
         repeat (3) @(negedge clk);
         chk(g, "reset ch_grant", ch_grant, 0);
         chk(g, "reset mem_wren", mem_wren, 0);
         chk(g, "reset busy", busy, 0);
         rst_n = 1'b1;
         @(negedge clk);

         if (g == 0) begin
            lin_mode = 1; len[0] = 256; len[1] = 10; len[2] = 5;
            pulse_start();
            chk(g, "first ch_start", ch_start, 3'b001);
            chk(g, "first ch_grant", ch_grant, 3'b001);
            chk(g, "first busy", busy, 1);
            wr = 0; last_a = '0; hit = 0;
            for (int i = 0; i < 400; i++) begin
               if (ch_start == 3'b010) begin
                  hit = 1;
                  break;
               end
               if (mem_wren) begin
                  wr++;
                  last_a = mem_addr;
               end
               @(negedge clk);
            end
            chk(g, "handoff reached", hit, 1);
            chk(g, "phase0 write count", wr, 256);
            chk(g, "phase0 last addr", last_a, 8'hFF);
            chk(g, "handoff mem_wren", mem_wren, 0);
            lin_mode = 0;
            wait_end(100);
            chk(g, "end phase", phase, 2);
            repeat (4) @(negedge clk);
            chk(g, "all_done held", all_done, 1);
            // reset mid-phase 1 while a write is on the port
            len[0] = 3; len[1] = 60; len[2] = 5;
            pulse_start();
            hit = 0;
            for (int i = 0; i < 60; i++) begin
               if (phase == 1 && mem_wren) begin
                  hit = 1;
                  break;
               end
               @(negedge clk);
            end
            chk(g, "phase1 write seen", hit, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk(g, "midreset mem_wren", mem_wren, 0);
            chk(g, "midreset mem_addr", mem_addr, 0);
            chk(g, "midreset phase", phase, 0);
            repeat (3) @(negedge clk);
            chk(g, "idle after reset", busy, 0);
         end

         if (g == 1) begin
            len[0] = 3; len[1] = 1000; len[2] = 5;
            pulse_start();
            for (int i = 0; i < 20 && ch_grant != 3'b010; i++) @(negedge clk);
            gcnt = 0;
            for (int i = 0; i < 100 && ch_grant == 3'b010; i++) begin
               gcnt++;
               @(negedge clk);
            end
            chk(g, "watchdog hold cycles", gcnt, 16);
            chk(g, "watchdog err", timeout_err, 1);
            chk(g, "watchdog all_done", all_done, 1);
            chk(g, "watchdog mem_wren", mem_wren, 0);
            chk(g, "watchdog phase", phase, 1);
            len[1] = 4;
            pulse_start();
            chk(g, "restart err clear", timeout_err, 0);
            chk(g, "restart all_done", all_done, 0);
            chk(g, "restart grant", ch_grant, 3'b001);
            wait_end(100);
         end

         if (g == 2) begin
            for (int k = 0; k < NC; k++) len[k] = 2 + k;
            pulse_start();
            for (int i = 0; i < 100 && !(all_done && !busy); i++) begin
               if (ch_grant != 0 && (seq.size() == 0 || seq[$] != ch_grant))
                  seq.push_back(ch_grant);
               @(negedge clk);
            end
            chk(g, "grant count", seq.size(), 4);
            for (int i = 0; i < 4 && i < seq.size(); i++)
               chk(g, "grant order", seq[i], 4'b0001 << i);
         end

         for (int r = 0; r < 25; r++) random_run(r);
         fin = 1;
      end
   end

   initial begin
      bit all_fin = 0;
      for (int i = 0; i < 80000; i++) begin
         @(posedge clk);
         all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin;
         if (all_fin) break;
      end
      n_tests++;
      if (!all_fin) begin
         n_fail++;
         $display("FAIL bench completion: got %0d, expected 1", all_fin);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_phase_arbiter.md
Name: mem_phase_arbiter

Overview:
- Parametrised successor to the three-loop memory port mux; owns the single-port RAM interface for a sequence of NUM_CH processing phases, e.g. RC4 init / shuffle / decrypt.
- Kicks each phase in order and grants that phase the registered RAM port until it reports done.
- Inserts a one-cycle write-guard between phases, then flags completion.
- Adds a per-phase watchdog with an error flag.

Parameters:
- NUM_CH, 3, number of phases/channels (>=2)
- DATA_W, 8, RAM data width
- ADDR_W, 8, RAM address width
- TIMEOUT_CYC, 0, max cycles a phase may hold the port; 0 disables the watchdog
- PH_W, $clog2(NUM_CH), phase index width (derived; minimum 1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE or DONE
- ch_wren  in  NUM_CH  per-channel write enable
- ch_data  in  NUM_CH*DATA_W  per-channel write data; channel k at bits [k*DATA_W +: DATA_W]
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel k at bits [k*ADDR_W +: ADDR_W]
- ch_done  in  NUM_CH  per-channel done; level or pulse
- ch_start  out  NUM_CH  one-hot, one-cycle kick to the channel entering its phase
- ch_grant  out  NUM_CH  one-hot, high while the channel owns the port
- mem_data  out  DATA_W  registered RAM write data
- mem_addr  out  ADDR_W  registered RAM address
- mem_wren  out  1  registered RAM write enable
- phase  out  PH_W  current phase index
- busy  out  1  high in RUN or HANDOFF
- all_done  out  1  sequence finished; held until restart
- timeout_err  out  1  watchdog fired; sticky until restart or reset

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0; watchdog counter 0. Reset takes effect from any state, mid-phase included, and outputs are 0 on the following cycle.
- States: IDLE, RUN, HANDOFF, DONE. All outputs are registered.
- IDLE and DONE, start=1:
  - phase<=0, ch_start<=onehot(0), ch_grant<=onehot(0)
  - all_done<=0, timeout_err<=0, counter<=0
  - next state RUN
- IDLE and DONE, start=0: hold state and outputs; mem_wren stays 0.
- RUN:
  - mem_data/mem_addr/mem_wren <= channel[phase] inputs every edge, so there is 1-cycle latency from channel to RAM.
  - ch_start<=0 after its single cycle.
  - Inputs from non-granted channels never reach mem_*.
  - ch_done of non-active channels is ignored.
- RUN exit on done: if ch_done[phase]=1, the same-edge capture still happens, so the final write lands. Then ch_grant<=0 and next state HANDOFF.
- Watchdog: the counter increments each RUN cycle. If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 without done:
  - timeout_err<=1, mem_wren<=0, ch_grant<=0
  - state<=DONE, all_done<=1
  - done arriving on the same edge wins over the timeout.
- HANDOFF (exactly 1 cycle): mem_wren<=0; mem_addr/mem_data hold.
  - If phase==NUM_CH-1: next state DONE, all_done<=1.
  - Otherwise: phase<=phase+1, ch_start/ch_grant<=onehot(phase+1), counter<=0, next state RUN.
- start while in RUN or HANDOFF: ignored.
- Level-held done: a channel holding done high re-enters only after a restart. On restart it is seen at the first RUN edge, giving a 1-cycle phase. This is legal and expected.
- busy is combinational from state; every other output is a flop.

Test Plan:
- Reset then start pulse at cycle 0: ch_start=3'b001 and ch_grant=3'b001 at cycle 1, busy=1. Ch0 drives addr 0..255 wren=1 data=addr, done with addr=255: RAM sees 256 writes, last at addr 8'hFF, then mem_wren=0 in HANDOFF and ch_start=3'b010.
- Full 3-phase sequence with ch1 done after 10 cycles and ch2 after 5: phase steps 0→1→2, exactly one HANDOFF cycle with mem_wren=0 between phases, all_done=1 with busy=0 after ch2, all_done held until next start.
- Isolation: during phase 1, ch0/ch2 drive wren=1 addr=8'hAA and pulse done → mem_addr never 8'hAA, phase unaffected.
- Watchdog with TIMEOUT_CYC=16, ch1 never done: timeout_err=1 and all_done=1 after 16 RUN cycles of phase 1, mem_wren=0. Restart clears both and begins at phase 0.
- Reset asserted mid-phase 1 with mem_wren=1: all outputs 0 on next cycle, state IDLE, start needed to resume from phase 0.
- NUM_CH=4, DATA_W=16, ADDR_W=10: 4-phase run completes with one-hot grants 4'b0001..4'b1000 and 16-bit data at 10-bit addresses passed intact.
